alu_iter: RTL
=============

ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal >= 8).
REQ-002 Parameter MUL_EN, default 1; 1 = iterative multiply unit present, 0 = absent.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block accepts request this cycle.
REQ-007 alu_control  input  4  opcode: AND=0 EOR=1 SUB=2 RSB=3 ADD=4 ADC=5 SBC=6 RSC=7 TST=8 TEQ=9 CMP=10 CMN=11 ORR=12 MOV=13 BIC=14 MVN=15.
REQ-008 mul  input  1  1 = multiply request; alu_control ignored.
REQ-009 acc  input  1  with mul=1, accumulate operand_c (MLA).
REQ-010 set_flags  input  1  update flag register (S bit).
REQ-011 operand_a, operand_b, operand_c  input  WIDTH each  operands (Rn, Op2, accumulator).
REQ-012 out_valid  output  1  one-cycle pulse, result/nzcv valid.
REQ-013 result  output  WIDTH  registered result.
REQ-014 nzcv  output  4  flag register {N,Z,C,V}.
REQ-015 result_writeback  output  1  result is to be written to register file.

Function
REQ-016 Request accepted when in_valid=1 and in_ready=1; operands/controls captured on that edge.
REQ-017 FSM states IDLE, MUL; in_ready=1 only in IDLE.
REQ-018 ALU op (mul=0 or MUL_EN=0): result, nzcv, result_writeback updated and out_valid=1 on the accepting edge (latency 1); FSM stays IDLE; back-to-back requests every cycle.
REQ-019 Arithmetic: SUB a-b, RSB b-a, ADD a+b, ADC a+b+C, SBC a-b-!C, RSC b-a-!C, CMP a-b, CMN a+b; C and CMP/SUB-family carry = NOT borrow; computed in WIDTH+1 bits.
REQ-020 C used as carry-in is the flag register value before the accepting edge.
REQ-021 Logical: AND, EOR, ORR, BIC a&~b, MOV b, MVN ~b, TST a&b, TEQ a^b.
REQ-022 Flags written when set_flags=1 or opcode in TST..CMN: N=result[WIDTH-1], Z=(result==0); arithmetic sets C=carry-out, V=signed overflow; logical leaves C,V unchanged.
REQ-023 Flags unchanged otherwise; nzcv holds between updates.
REQ-024 result_writeback=0 for TST/TEQ/CMP/CMN, 1 for all other accepted ops; result register still loaded with computed value for compare ops.
REQ-025 Multiply (mul=1, MUL_EN=1): IDLE->MUL; radix-2 shift-add, one partial product per cycle, WIDTH cycles; result = low WIDTH bits of a*b (+c if acc), unsigned/modulo.
REQ-026 Multiply completion: MUL->IDLE on WIDTH-th iteration edge; result loaded, out_valid=1, result_writeback=1 on that edge; total latency WIDTH cycles from accept.
REQ-027 Multiply flags: if set_flags, N,Z updated from final result; C,V unchanged.
REQ-028 in_valid during MUL ignored (in_ready=0); no state or flag change.
REQ-029 out_valid=0 in all cycles with no completion; result/result_writeback hold last value.
REQ-030 No output backpressure; consumer samples out_valid pulse.

Reset
REQ-031 On reset edge: result=0, nzcv=0000, out_valid=0, result_writeback=0, FSM=IDLE, in_ready=1.
REQ-032 Reset during MUL aborts multiply; no out_valid pulse, flags cleared; reset overrides simultaneous accept.

Verification
REQ-033 WIDTH=32: ADD 10+20, set_flags=1 -> next cycle result=30, nzcv=0000, out_valid=1, result_writeback=1.
REQ-034 SUB 0-1, set_flags=1 -> result=0xFFFFFFFF, nzcv=1000; then ADC 0x7FFFFFFF+0 with C=0 -> 0x7FFFFFFF; after CMP 5,3 (C=1) ADC 0x7FFFFFFF+0 -> 0x80000000, nzcv=1001.
REQ-035 CMP 5,5 -> nzcv=0110, result_writeback=0; TST 0,0 after it -> Z=1, C unchanged; back-to-back accepts every cycle.
REQ-036 MLA a=7 b=6 c=3, set_flags=1 -> in_ready=0 for 32 cycles, single out_valid with result=45, N=0 Z=0, C,V preserved; in_valid during busy ignored.
REQ-037 Reset asserted mid-multiply -> no out_valid, outputs per REQ-031 next edge, new request accepted next cycle.
REQ-038 WIDTH=8, MUL_EN=0: ADD 0x7F+0x01 -> 0x80, nzcv=1001; mul=1 request treated as ALU op with latency 1.

Source files
------------

// File: rtl/alu_iter_if.sv
// ----------------------------------------------------------------------------
// alu_iter_if
// Request/response bundle for the iterative ALU.
//   master : requester side (drives requests, observes results)
//   slave  : ALU side (accepts requests, produces results)
// Signals:
//   in_valid/in_ready       request handshake
//   alu_control[3:0]        ALU opcode
//   mul, acc                multiply request / accumulate operand_c
//   set_flags               update the flag register
//   operand_a/b/c[WIDTH]    Rn, Op2, accumulator
//   out_valid               one-cycle completion pulse
//   result[WIDTH]           registered result
//   nzcv[3:0]               flag register {N,Z,C,V}
//   result_writeback        result is destined for the register file
// ----------------------------------------------------------------------------
interface alu_iter_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_control;
    logic             mul;
    logic             acc;
    logic             set_flags;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] operand_c;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic [3:0]       nzcv;
    logic             result_writeback;

    modport master (
        output in_valid, alu_control, mul, acc, set_flags,
               operand_a, operand_b, operand_c,
        input  in_ready, out_valid, result, nzcv, result_writeback
    );

    modport slave (
        input  in_valid, alu_control, mul, acc, set_flags,
               operand_a, operand_b, operand_c,
        output in_ready, out_valid, result, nzcv, result_writeback
    );
endinterface

// File: rtl/alu_iter.sv
// ----------------------------------------------------------------------------
// alu_iter
// ARM-style ALU with single-cycle data-processing ops and an optional
// radix-2 shift-add multiplier (one partial product per cycle, WIDTH cycles).
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   bus    : alu_iter_if.slave (request handshake, operands, result, flags)
// Parameters:
//   WIDTH  : operand/result width (>= 8)
//   MUL_EN : 1 = multiplier present; 0 = mul requests execute as ALU ops
// ----------------------------------------------------------------------------
module alu_iter #(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input  logic       clk,
    input  logic       reset,
    alu_iter_if.slave  bus
);

    localparam int CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam bit HAS_MUL = (MUL_EN != 0);

    typedef enum logic [3:0] {
        OP_AND = 4'd0,  OP_EOR = 4'd1,  OP_SUB = 4'd2,  OP_RSB = 4'd3,
        OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SBC = 4'd6,  OP_RSC = 4'd7,
        OP_TST = 4'd8,  OP_TEQ = 4'd9,  OP_CMP = 4'd10, OP_CMN = 4'd11,
        OP_ORR = 4'd12, OP_MOV = 4'd13, OP_BIC = 4'd14, OP_MVN = 4'd15
    } alu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
        logic             arith;
    } alu_out_t;

    // All arithmetic ops reduce to x + y + cin in WIDTH+1 bits. Subtraction
    // uses the one's complement of the subtrahend, so the carry-out is the
    // inverted borrow. Logical ops flag arith=0 so C,V are left alone.
    function automatic alu_out_t alu_compute(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             c_in
    );
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic             cin;
        logic [WIDTH:0]   sum;
        alu_out_t         o;
        x       = a;
        y       = b;
        cin     = 1'b0;
        o       = '0;
        o.arith = 1'b1;
        case (op)
            OP_SUB, OP_CMP: begin y = ~b; cin = 1'b1; end
            OP_RSB:         begin x = b; y = ~a; cin = 1'b1; end
            OP_ADD, OP_CMN: begin cin = 1'b0; end
            OP_ADC:         begin cin = c_in; end
            OP_SBC:         begin y = ~b; cin = c_in; end
            OP_RSC:         begin x = b; y = ~a; cin = c_in; end
            default:        begin o.arith = 1'b0; end
        endcase
        sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
        if (o.arith) begin
            o.res = sum[WIDTH-1:0];
            o.c   = sum[WIDTH];
            o.v   = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
        end else begin
            case (op)
                OP_AND, OP_TST: o.res = a & b;
                OP_EOR, OP_TEQ: o.res = a ^ b;
                OP_ORR:         o.res = a | b;
                OP_MOV:         o.res = b;
                OP_BIC:         o.res = a & ~b;
                OP_MVN:         o.res = ~b;
                default:        o.res = '0;
            endcase
        end
        return o;
    endfunction

    state_e           state;
    state_e           state_nxt;
    logic             in_ready;
    logic             accept;
    logic             is_mul;
    logic             is_cmp;
    logic             alu_flag_we;
    alu_out_t         alu_res;

    logic [WIDTH-1:0] result_q;
    logic [3:0]       nzcv_q;
    logic             out_valid_q;
    logic             wb_q;

    logic [WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0] mul_mcand;
    logic [WIDTH-1:0] mul_mplier;
    logic [CNT_W-1:0] mul_cnt;
    logic             mul_sf;
    logic             mul_last;
    logic [WIDTH-1:0] mul_final;

    assign is_mul      = HAS_MUL && bus.mul;
    assign accept      = bus.in_valid && in_ready;
    assign is_cmp      = (bus.alu_control[3:2] == 2'b10);
    assign alu_flag_we = bus.set_flags || is_cmp;
    assign alu_res     = alu_compute(bus.alu_control, bus.operand_a,
                                     bus.operand_b, nzcv_q[1]);

    // The last iteration folds its partial product straight into the result
    // register, so the multiply completes on the WIDTH-th edge after accept.
    assign mul_last  = (mul_cnt == CNT_W'(WIDTH - 1));
    assign mul_final = mul_prod + (mul_mplier[0] ? mul_mcand : '0);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state / handshake
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid && is_mul) begin
                    state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                if (mul_last) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Multiplier datapath: operands captured on accept, then one shift-add
    // step per cycle while busy. Accumulator seeds the product for MLA.
    always_ff @(posedge clk) begin
        if (accept && is_mul) begin
            mul_mcand  <= bus.operand_a;
            mul_mplier <= bus.operand_b;
            mul_prod   <= bus.acc ? bus.operand_c : '0;
            mul_cnt    <= '0;
            mul_sf     <= bus.set_flags;
        end else if (state == S_MUL) begin
            if (mul_mplier[0]) begin
                mul_prod <= mul_prod + mul_mcand;
            end
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_cnt    <= mul_cnt + CNT_W'(1);
        end
    end

    // Output stage: result, flags, writeback and completion pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q    <= '0;
            nzcv_q      <= 4'b0000;
            out_valid_q <= 1'b0;
            wb_q        <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (accept && !is_mul) begin
                result_q    <= alu_res.res;
                wb_q        <= !is_cmp;
                out_valid_q <= 1'b1;
                if (alu_flag_we) begin
                    nzcv_q <= {alu_res.res[WIDTH-1],
                               (alu_res.res == '0),
                               alu_res.arith ? alu_res.c : nzcv_q[1],
                               alu_res.arith ? alu_res.v : nzcv_q[0]};
                end
            end else if (state == S_MUL && mul_last) begin
                result_q    <= mul_final;
                wb_q        <= 1'b1;
                out_valid_q <= 1'b1;
                if (mul_sf) begin
                    nzcv_q[3:2] <= {mul_final[WIDTH-1], (mul_final == '0)};
                end
            end
        end
    end

    assign bus.in_ready         = in_ready;
    assign bus.result           = result_q;
    assign bus.nzcv             = nzcv_q;
    assign bus.out_valid        = out_valid_q;
    assign bus.result_writeback = wb_q;

endmodule
